// File: rtl/mac_sequencer_if.sv
// Handshake and datapath-control bundle between the FFT MAC sequencer and its datapath.
// The master side is the sequencer; the slave side is the requester and datapath.
interface mac_sequencer_if #(
  parameter int LOG2N = 5
);
  logic             start;
  logic             hold;
  logic             ready;
  logic             busy;
  logic             done;
  logic [2:0]       stage;
  logic [LOG2N-2:0] bfly;
  logic [LOG2N-1:0] addr_A;
  logic [LOG2N-1:0] addr_B;
  logic [LOG2N-2:0] tw_idx;
  logic             sel_BI;
  logic             sel_WI;
  logic             mac_sub;
  logic             rst_signal;
  logic             Ld_R;
  logic             Ld_I;
  logic             wr_en;

  modport master (
    input  start, hold,
    output ready, busy, done, stage, bfly, addr_A, addr_B, tw_idx,
           sel_BI, sel_WI, mac_sub, rst_signal, Ld_R, Ld_I, wr_en
  );

  modport slave (
    output start, hold,
    input  ready, busy, done, stage, bfly, addr_A, addr_B, tw_idx,
           sel_BI, sel_WI, mac_sub, rst_signal, Ld_R, Ld_I, wr_en
  );
endinterface

// File: rtl/mac_sequencer.sv
// Radix-2 FFT butterfly sequencer: walks every stage/butterfly pair and emits the
// eight-step complex MAC control sequence plus operand and twiddle addresses.
module mac_sequencer #(
  parameter int LOG2N = 5
) (
  input logic            clk_MAC,
  input logic            rst,
  mac_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, CLR, P0, P1, LDR, P2, P3, LDI, WB, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       stage_q, stage_d;
  logic [LOG2N-2:0] bfly_q, bfly_d;

  logic ready_q, busy_q, done_q, rstSig_q;
  logic selBI_q, selWI_q, macSub_q, ldR_q, ldI_q, wrEn_q;

  logic             lastBfly, lastStage;
  logic [LOG2N-1:0] bflyExt, span, low, addrA, addrB;
  logic [3:0]       stageP1, twShift;
  logic [LOG2N-2:0] twIdx;

  assign lastBfly  = &bfly_q;
  assign lastStage = (stage_q == 3'(LOG2N - 1));

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    if (!bus.hold) begin
      case (state_q)
        IDLE: if (bus.start) state_d = CLR;
        CLR:  state_d = P0;
        P0:   state_d = P1;
        P1:   state_d = LDR;
        LDR:  state_d = P2;
        P2:   state_d = P3;
        P3:   state_d = LDI;
        LDI:  state_d = WB;
        WB: begin
          if (lastBfly && lastStage) begin
            state_d = DONE;
            stage_d = '0;
            bfly_d  = '0;
          end else begin
            state_d = CLR;
            bfly_d  = bfly_q + 1'b1;
            if (lastBfly) stage_d = stage_q + 3'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_MAC or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      stage_q  <= '0;
      bfly_q   <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rstSig_q <= 1'b0;
      selBI_q  <= 1'b0;
      selWI_q  <= 1'b0;
      macSub_q <= 1'b0;
      ldR_q    <= 1'b0;
      ldI_q    <= 1'b0;
      wrEn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      bfly_q   <= bfly_d;
      ready_q  <= (state_d == IDLE);
      busy_q   <= (state_d inside {CLR, P0, P1, LDR, P2, P3, LDI, WB});
      done_q   <= (state_d == DONE);
      rstSig_q <= (state_d == CLR);
      selBI_q  <= (state_d inside {P1, P3});
      selWI_q  <= (state_d inside {P1, P2});
      macSub_q <= (state_d == P1);
      ldR_q    <= (state_d == LDR);
      ldI_q    <= (state_d == LDI);
      wrEn_q   <= (state_d == WB);
    end
  end

  // Butterfly pairs sit span apart inside groups of 2*span; twiddle stride shrinks per stage.
  always_comb begin
    bflyExt = {1'b0, bfly_q};
    span    = LOG2N'(1) << stage_q;
    low     = bflyExt & (span - LOG2N'(1));
    stageP1 = {1'b0, stage_q} + 4'd1;
    addrA   = ((bflyExt >> stage_q) << stageP1) | low;
    addrB   = addrA + span;
    twShift = 4'(LOG2N - 1) - {1'b0, stage_q};
    twIdx   = low[LOG2N-2:0] << twShift;
  end

  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.stage   = stage_q;
  assign bus.bfly    = bfly_q;
  assign bus.sel_BI  = selBI_q;
  assign bus.sel_WI  = selWI_q;
  assign bus.mac_sub = macSub_q;
  assign bus.addr_A  = busy_q ? addrA : '0;
  assign bus.addr_B  = busy_q ? addrB : '0;
  assign bus.tw_idx  = busy_q ? twIdx : '0;

  // A stall suppresses every side-effecting strobe; it re-fires once hold drops.
  assign bus.rst_signal = rstSig_q & ~bus.hold;
  assign bus.Ld_R       = ldR_q    & ~bus.hold;
  assign bus.Ld_I       = ldI_q    & ~bus.hold;
  assign bus.wr_en      = wrEn_q   & ~bus.hold;
  assign bus.done       = done_q   & ~bus.hold;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer (N=32): per-cycle scoreboard of every output
// against a positional model, plus spot checks of pass timing, holds and resets.
module tb_mac_sequencer;

  localparam int LOG2N = 5;

  typedef struct packed {
    logic       ready, busy, done, rstSig, selBI, selWI, macSub, ldR, ldI, wrEn;
    logic [2:0] stage;
    logic [3:0] bfly;
    logic [4:0] addrA, addrB;
    logic [3:0] tw;
  } snap_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  snap_t obsQ[$];
  snap_t expQ[$];
  snap_t hist[$];

  mac_sequencer_if #(.LOG2N(LOG2N)) bus ();

  mac_sequencer #(.LOG2N(LOG2N)) dut (
    .clk_MAC (clk),
    .rst     (rst),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs as a function of cycles since the start request.
  function automatic snap_t modelSnap(input int rel, input bit held);
    snap_t s;
    int k, ph, st, b, span, g, j;
    s = '0;
    if (rel <= 0 || rel > 641) begin
      s.ready = 1'b1;
    end else if (rel == 641) begin
      s.done = !held;
    end else begin
      k    = (rel - 1) / 8;
      ph   = (rel - 1) % 8;
      st   = k / 16;
      b    = k % 16;
      span = 1 << st;
      g    = b / span;
      j    = b % span;
      s.busy  = 1'b1;
      s.stage = 3'(st);
      s.bfly  = 4'(b);
      s.addrA = 5'(g * 2 * span + j);
      s.addrB = 5'(g * 2 * span + j + span);
      s.tw    = 4'(j * (16 / span));
      case (ph)
        0: s.rstSig = !held;
        2: begin s.selBI = 1'b1; s.selWI = 1'b1; s.macSub = 1'b1; end
        3: s.ldR = !held;
        4: s.selWI = 1'b1;
        5: s.selBI = 1'b1;
        6: s.ldI = !held;
        7: s.wrEn = !held;
        default: ;
      endcase
    end
    return s;
  endfunction

  function automatic snap_t capture();
    snap_t s;
    s.ready  = bus.ready;
    s.busy   = bus.busy;
    s.done   = bus.done;
    s.rstSig = bus.rst_signal;
    s.selBI  = bus.sel_BI;
    s.selWI  = bus.sel_WI;
    s.macSub = bus.mac_sub;
    s.ldR    = bus.Ld_R;
    s.ldI    = bus.Ld_I;
    s.wrEn   = bus.wr_en;
    s.stage  = bus.stage;
    s.bfly   = bus.bfly;
    s.addrA  = bus.addr_A;
    s.addrB  = bus.addr_B;
    s.tw     = bus.tw_idx;
    return s;
  endfunction

  function automatic int countWr();
    int n = 0;
    foreach (hist[i]) if (hist[i].wrEn === 1'b1) n++;
    return n;
  endfunction

  function automatic int countDone();
    int n = 0;
    foreach (hist[i]) if (hist[i].done === 1'b1) n++;
    return n;
  endfunction

  function automatic int lastDone();
    int at = -1;
    foreach (hist[i]) if (hist[i].done === 1'b1) at = i;
    return at;
  endfunction

  // Entered and left #1 after a rising edge; cycle 0 is the cycle start is first high.
  task automatic runPass(input int nCyc, input int holdStart, input int holdLen,
                         input int startAgainAt, input int resetAt);
    for (int cyc = 0; cyc < nCyc; cyc++) begin
      bus.start = (cyc == 0) || (cyc == startAgainAt);
      bus.hold  = (cyc >= holdStart) && (cyc < holdStart + holdLen);
      if (cyc == resetAt) rst = 1'b0;
      if (cyc == resetAt + 2) rst = 1'b1;
      @(negedge clk);
      obsQ.push_back(capture());
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
  endtask

  task automatic test_reset();
    snap_t o;
    snap_t idle;
    idle = modelSnap(0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = capture();
    tests++;
    if (o !== idle) begin
      fails++;
      $display("[TB] FAIL reset_hold: got %h expected %h", o, idle);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    o = capture();
    tests++;
    if (o !== idle) begin
      fails++;
      $display("[TB] FAIL reset_release: got %h expected %h", o, idle);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_pass();
    snap_t e, o;
    int idx;
    obsQ.delete(); expQ.delete();
    for (int c = 0; c < 650; c++) expQ.push_back(modelSnap(c, 1'b0));
    runPass(650, -1, 0, -1, -10);
    hist = obsQ;
    idx = 0;
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("[TB] FAIL full_pass cyc %0d: got %h expected %h", idx, o, e);
      end
      idx++;
    end
    tests++;
    if (hist[1].rstSig !== 1'b1 || hist[0].busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL first_clr: got rst_signal %b at cycle 1 expected 1", hist[1].rstSig);
    end
    tests++;
    if (hist[640].wrEn !== 1'b1 || hist[641].busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL last_wb: got wr_en %b busy_after %b expected 1 0", hist[640].wrEn, hist[641].busy);
    end
    tests++;
    if (countDone() != 1 || lastDone() != 641) begin
      fails++;
      $display("[TB] FAIL done_pulse: got %0d pulses last at %0d expected 1 at 641", countDone(), lastDone());
    end
    tests++;
    if (hist[642].ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_back: got %b expected 1", hist[642].ready);
    end
    tests++;
    if ({hist[5].addrA, hist[5].addrB, hist[5].tw} !== {5'd0, 5'd1, 4'd0}) begin
      fails++;
      $display("[TB] FAIL addr_s0b0: got %0d %0d %0d expected 0 1 0", hist[5].addrA, hist[5].addrB, hist[5].tw);
    end
    tests++;
    if ({hist[297].stage, hist[297].bfly, hist[297].addrA, hist[297].addrB, hist[297].tw}
        !== {3'd2, 4'd5, 5'd9, 5'd13, 4'd4}) begin
      fails++;
      $display("[TB] FAIL addr_s2b5: got %0d %0d %0d expected 9 13 4", hist[297].addrA, hist[297].addrB, hist[297].tw);
    end
    tests++;
    if ({hist[633].stage, hist[633].bfly, hist[633].addrA, hist[633].addrB, hist[633].tw}
        !== {3'd4, 4'd15, 5'd15, 5'd31, 4'd15}) begin
      fails++;
      $display("[TB] FAIL addr_s4b15: got %0d %0d %0d expected 15 31 15", hist[633].addrA, hist[633].addrB, hist[633].tw);
    end
  endtask

  task automatic test_hold_ldr();
    snap_t e, o;
    int idx, ldrCount;
    obsQ.delete(); expQ.delete();
    for (int c = 0; c < 655; c++) begin
      if (c <= 3)      expQ.push_back(modelSnap(c, 1'b0));
      else if (c <= 6) expQ.push_back(modelSnap(4, 1'b1));
      else             expQ.push_back(modelSnap(c - 3, 1'b0));
    end
    runPass(655, 4, 3, -1, -10);
    hist = obsQ;
    idx = 0;
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("[TB] FAIL hold_ldr cyc %0d: got %h expected %h", idx, o, e);
      end
      idx++;
    end
    ldrCount = 0;
    for (int c = 4; c <= 7; c++) if (hist[c].ldR === 1'b1) ldrCount++;
    tests++;
    if (ldrCount != 1 || hist[7].ldR !== 1'b1) begin
      fails++;
      $display("[TB] FAIL hold_ldr_pulse: got %0d pulses expected 1 at cycle 7", ldrCount);
    end
    tests++;
    if (lastDone() != 644 || countDone() != 1) begin
      fails++;
      $display("[TB] FAIL hold_ldr_length: got done at %0d expected 644", lastDone());
    end
  endtask

  task automatic test_idle_hold();
    snap_t e, o;
    int idx;
    obsQ.delete(); expQ.delete();
    for (int c = 0; c < 655; c++) expQ.push_back(modelSnap((c <= 3) ? 0 : c - 3, 1'b0));
    runPass(655, 0, 3, 3, -10);
    hist = obsQ;
    idx = 0;
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("[TB] FAIL idle_hold cyc %0d: got %h expected %h", idx, o, e);
      end
      idx++;
    end
    tests++;
    if (hist[3].busy !== 1'b0 || hist[4].rstSig !== 1'b1) begin
      fails++;
      $display("[TB] FAIL idle_hold_start: got busy %b clr %b expected 0 1", hist[3].busy, hist[4].rstSig);
    end
  endtask

  task automatic test_done_hold();
    snap_t e, o;
    int idx;
    obsQ.delete(); expQ.delete();
    for (int c = 0; c < 650; c++) begin
      if (c <= 640)      expQ.push_back(modelSnap(c, 1'b0));
      else if (c <= 642) expQ.push_back(modelSnap(641, 1'b1));
      else               expQ.push_back(modelSnap(c - 2, 1'b0));
    end
    runPass(650, 641, 2, -1, -10);
    hist = obsQ;
    idx = 0;
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("[TB] FAIL done_hold cyc %0d: got %h expected %h", idx, o, e);
      end
      idx++;
    end
    tests++;
    if (countDone() != 1 || lastDone() != 643) begin
      fails++;
      $display("[TB] FAIL done_hold_pulse: got %0d pulses at %0d expected 1 at 643", countDone(), lastDone());
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    int idx;
    obsQ.delete(); expQ.delete();
    for (int c = 0; c < 650; c++) expQ.push_back(modelSnap(c, 1'b0));
    runPass(650, -1, 0, 100, -10);
    hist = obsQ;
    idx = 0;
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("[TB] FAIL busy_start cyc %0d: got %h expected %h", idx, o, e);
      end
      idx++;
    end
    tests++;
    if (countWr() != 80 || countDone() != 1) begin
      fails++;
      $display("[TB] FAIL busy_start_counts: got %0d wr_en %0d done expected 80 1", countWr(), countDone());
    end
  endtask

  task automatic test_reset_midpass();
    snap_t e, o;
    int idx;
    obsQ.delete(); expQ.delete();
    for (int c = 0; c < 1050; c++) begin
      if (c < 400)       expQ.push_back(modelSnap(c, 1'b0));
      else if (c <= 402) expQ.push_back(modelSnap(0, 1'b0));
      else               expQ.push_back(modelSnap(c - 402, 1'b0));
    end
    runPass(1050, -1, 0, 402, 400);
    hist = obsQ;
    idx = 0;
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("[TB] FAIL reset_mid cyc %0d: got %h expected %h", idx, o, e);
      end
      idx++;
    end
    tests++;
    if (hist[399].stage !== 3'd3 || hist[400].ready !== 1'b1 || hist[400].busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_abort: got stage %0d ready %b busy %b expected 3 1 0",
               hist[399].stage, hist[400].ready, hist[400].busy);
    end
    tests++;
    if (countDone() != 1 || lastDone() != 1043 || countWr() != 129) begin
      fails++;
      $display("[TB] FAIL reset_mid_rerun: got %0d done at %0d, %0d wr_en expected 1 at 1043, 129",
               countDone(), lastDone(), countWr());
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    #3 rst = 1'b0;
    test_reset();
    test_full_pass();
    test_hold_ldr();
    test_idle_hold();
    test_done_hold();
    test_back_to_back();
    test_reset_midpass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
